// File: rtl/sms_timing_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sms_timing_pkg : shared types/constants for the SMS timing ring       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package sms_timing_pkg;

  localparam int DEF_PHASES = 10;
  localparam int DEF_TICKS  = 4;
  localparam int DEF_CNT_W  = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PRESET = 2'd1,
    ST_RUN    = 2'd2
  } state_e;

  // Gates are open only inside the phase; first and last tick are guard bands.
  function automatic logic gate_active(input int tick, input int ticks);
    return (tick >= 1) && (tick <= ticks - 2);
  endfunction

endpackage : sms_timing_pkg
`default_nettype wire

// File: rtl/sms_phase_ring.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sms_phase_ring : one-hot phase shift register, clear to phase 0       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module sms_phase_ring #(
  parameter int PHASES = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              adv,
  output logic [PHASES-1:0] phase
);

  localparam logic [PHASES-1:0] C_PHASE0 = PHASES'(1);

  logic [PHASES-1:0] phase_d;
  logic [PHASES-1:0] phase_q;

  always_comb begin
    phase_d = phase_q;
    if (clr) begin
      phase_d = C_PHASE0;
    end else if (adv) begin
      phase_d = {phase_q[PHASES-2:0], phase_q[PHASES-1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= C_PHASE0;
    end else begin
      phase_q <= phase_d;
    end
  end

  assign phase = phase_q;

endmodule : sms_phase_ring
`default_nettype wire

// File: rtl/sms_timing_ring.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sms_timing_ring : ten-phase DFD timing ring with start/stop control  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module sms_timing_ring
  import sms_timing_pkg::*;
#(
  parameter int PHASES = DEF_PHASES,
  parameter int TICKS  = DEF_TICKS,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop_req,
  input  logic              single_cycle,
  output logic [PHASES-1:0] phase_gate,
  output logic              set_n,
  output logic              reset_n,
  output logic              cycle_end,
  output logic              running,
  output logic [CNT_W-1:0]  cycle_count
);

  localparam int             TW        = $clog2(TICKS);
  localparam logic [TW-1:0]  TICK_LAST = TW'(TICKS - 1);

  state_e             state_d, state_q;
  logic [TW-1:0]      tick_d, tick_q;
  logic               stop_d, stop_q;
  logic [CNT_W-1:0]   cycle_count_d, cycle_count_q;
  logic               ring_clr, ring_adv;
  logic [PHASES-1:0]  ring;
  logic               end_now;

  logic [PHASES-1:0]  phase_gate_d, phase_gate_q;
  logic               set_n_d, set_n_q;
  logic               reset_n_d, reset_n_q;
  logic               cycle_end_d, cycle_end_q;
  logic               running_d, running_q;

  sms_phase_ring #(
    .PHASES (PHASES)
  ) u_ring (
    .clk   (clk),
    .rst   (rst),
    .clr   (ring_clr),
    .adv   (ring_adv),
    .phase (ring)
  );

  always_comb begin
    state_d       = state_q;
    tick_d        = tick_q;
    stop_d        = stop_q;
    cycle_count_d = cycle_count_q;
    ring_clr      = 1'b0;
    ring_adv      = 1'b0;
    end_now       = (state_q == ST_RUN) && (tick_q == TICK_LAST) && ring[PHASES-1];

    case (state_q)
      ST_IDLE: begin
        ring_clr = 1'b1;
        tick_d   = '0;
        stop_d   = 1'b0;
        if (start) begin
          state_d = ST_PRESET;
        end
      end
      ST_PRESET: begin
        ring_clr = 1'b1;
        tick_d   = '0;
        state_d  = ST_RUN;
      end
      ST_RUN: begin
        stop_d = stop_q | stop_req;
        if (tick_q == TICK_LAST) begin
          tick_d   = '0;
          ring_adv = 1'b1;
        end else begin
          tick_d = tick_q + TW'(1);
        end
        // A stop requested on the final tick itself still ends this cycle.
        if (end_now) begin
          cycle_count_d = cycle_count_q + CNT_W'(1);
          if (stop_q || stop_req || single_cycle) begin
            state_d = ST_IDLE;
            stop_d  = 1'b0;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are registered images of the current internal state.
    phase_gate_d = ((state_q == ST_RUN) && gate_active(int'(tick_q), TICKS)) ? ring : '0;
    set_n_d      = (state_q != ST_PRESET);
    reset_n_d    = !end_now;
    cycle_end_d  = end_now;
    running_d    = (state_q != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      tick_q        <= '0;
      stop_q        <= 1'b0;
      cycle_count_q <= '0;
      phase_gate_q  <= '0;
      set_n_q       <= 1'b1;
      reset_n_q     <= 1'b1;
      cycle_end_q   <= 1'b0;
      running_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      tick_q        <= tick_d;
      stop_q        <= stop_d;
      cycle_count_q <= cycle_count_d;
      phase_gate_q  <= phase_gate_d;
      set_n_q       <= set_n_d;
      reset_n_q     <= reset_n_d;
      cycle_end_q   <= cycle_end_d;
      running_q     <= running_d;
    end
  end

  assign phase_gate  = phase_gate_q;
  assign set_n       = set_n_q;
  assign reset_n     = reset_n_q;
  assign cycle_end   = cycle_end_q;
  assign running     = running_q;
  assign cycle_count = cycle_count_q;

endmodule : sms_timing_ring
`default_nettype wire

// File: tb/tb_sms_timing_ring.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_sms_timing_ring : scoreboard + vector-table bench for the ring    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_sms_timing_ring;

  localparam int PH  = 10;
  localparam int TK  = 4;
  localparam int CW  = 16;
  localparam int LEN = PH * TK;
  localparam logic [PH-1:0] C_ONE = PH'(1);

  logic clk = 1'b0;
  logic rst, start, stop_req, single_cycle;

  logic [PH-1:0] phase_gate, phase_gate2;
  logic          set_n, reset_n, cycle_end, running;
  logic          set_n2, reset_n2, cycle_end2, running2;
  logic [CW-1:0] cycle_count;
  logic [1:0]    cycle_count2;

  always #5 clk = ~clk;

  sms_timing_ring #(.PHASES(PH), .TICKS(TK), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .stop_req(stop_req),
    .single_cycle(single_cycle), .phase_gate(phase_gate), .set_n(set_n),
    .reset_n(reset_n), .cycle_end(cycle_end), .running(running),
    .cycle_count(cycle_count)
  );

  sms_timing_ring #(.PHASES(PH), .TICKS(TK), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .start(start), .stop_req(stop_req),
    .single_cycle(single_cycle), .phase_gate(phase_gate2), .set_n(set_n2),
    .reset_n(reset_n2), .cycle_end(cycle_end2), .running(running2),
    .cycle_count(cycle_count2)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: 0 idle, 1 preset, 2 run; pos = phase*TK + tick
  int          m_st   = 0;
  int          m_pos  = 0;
  int          m_stop = 0;
  int unsigned m_cnt  = 0;

  typedef struct packed {
    logic [PH-1:0] gate;
    logic          set_n;
    logic          reset_n;
    logic          cend;
    logic          run;
    logic [CW-1:0] cnt;
    logic [1:0]    cnt2;
  } exp_t;

  exp_t sb[$];

  typedef struct {
    logic r, s, sp, sc;
    int   n;
    logic run;
    int   cnt;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
    end
  endtask

  task automatic step(input logic r, input logic s, input logic sp, input logic sc);
    exp_t e;
    exp_t g;
    int   tk, ph;
    logic endc;
    rst = r; start = s; stop_req = sp; single_cycle = sc;
    tk   = m_pos % TK;
    ph   = m_pos / TK;
    endc = (m_st == 2) && (m_pos == LEN - 1);
    if (r) begin
      e = '{gate: '0, set_n: 1'b1, reset_n: 1'b1, cend: 1'b0, run: 1'b0, cnt: '0, cnt2: '0};
      m_st = 0; m_pos = 0; m_stop = 0; m_cnt = 0;
    end else begin
      e.gate    = (m_st == 2 && tk >= 1 && tk <= TK - 2) ? (C_ONE << ph) : '0;
      e.set_n   = (m_st != 1);
      e.reset_n = !endc;
      e.cend    = endc;
      e.run     = (m_st != 0);
      e.cnt     = CW'(m_cnt + (endc ? 1 : 0));
      e.cnt2    = 2'(m_cnt + (endc ? 1 : 0));
      if (m_st == 0) begin
        if (s) m_st = 1;
      end else if (m_st == 1) begin
        m_st = 2; m_pos = 0;
      end else begin
        if (sp) m_stop = 1;
        if (endc) begin
          m_cnt++;
          m_pos = 0;
          if (m_stop != 0 || sc) begin
            m_st = 0; m_stop = 0;
          end
        end else begin
          m_pos++;
        end
      end
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    g = sb.pop_front();
    chk("phase_gate", 32'(phase_gate), 32'(g.gate));
    chk("pulses", {28'd0, set_n, reset_n, cycle_end, running},
        {28'd0, g.set_n, g.reset_n, g.cend, g.run});
    chk("cycle_count", 32'(cycle_count), 32'(g.cnt));
    chk("cycle_count_w2", 32'(cycle_count2), 32'(g.cnt2));
    chk("gate_onehot", 32'($onehot0(phase_gate)), 32'd1);
    chk("gate_match_w2", 32'(phase_gate2), 32'(g.gate));
  endtask

  initial begin : main
    logic [1:0] seq [5];
    rst = 1'b1; start = 1'b0; stop_req = 1'b0; single_cycle = 1'b0;
    seq[0] = 2'd1; seq[1] = 2'd2; seq[2] = 2'd3; seq[3] = 2'd0; seq[4] = 2'd1;

    //               r     s     sp    sc    n    run   cnt
    tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b0,  2, 1'b0, 0});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 1'b0,  1, 1'b0, 0});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0,  1, 1'b1, 0});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 40, 1'b1, 1});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 40, 1'b1, 2});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 17, 1'b1, 2});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 1'b0,  1, 1'b1, 2});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 22, 1'b1, 3});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0,  1, 1'b0, 3});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 1'b1,  1, 1'b0, 3});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 41, 1'b1, 4});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b1,  1, 1'b0, 4});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 1'b1,  1, 1'b0, 4});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 42, 1'b0, 5});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 1'b0,  1, 1'b0, 5});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 60, 1'b1, 6});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0,  6, 1'b1, 6});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b0,  1, 1'b0, 0});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0,  3, 1'b0, 0});
    tbl.push_back('{1'b0, 1'b1, 1'b1, 1'b0,  1, 1'b0, 0});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 41, 1'b1, 1});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0,  1, 1'b1, 1});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 38, 1'b1, 1});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 1'b0,  1, 1'b1, 2});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0,  1, 1'b0, 2});

    for (int i = 0; i < tbl.size(); i++) begin
      for (int k = 0; k < tbl[i].n; k++) begin
        step(tbl[i].r, tbl[i].s, tbl[i].sp, tbl[i].sc);
      end
      chk($sformatf("row%0d_running", i), 32'(running), 32'(tbl[i].run));
      chk($sformatf("row%0d_count", i), 32'(cycle_count), 32'(tbl[i].cnt));
    end

    // Narrow counter wraps: 1,2,3,0,1 over five back-to-back cycles
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 5; c++) begin
      for (int k = 0; k < LEN; k++) begin
        step(1'b0, 1'b0, 1'b0, 1'b0);
      end
      chk($sformatf("wrap_cycle%0d", c), 32'(cycle_count2), 32'(seq[c]));
      chk($sformatf("wrap_cend%0d", c), 32'(cycle_end2), 32'd1);
    end

    // Stop mid-cycle and confirm everything parks with gates closed
    step(1'b0, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < LEN; k++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0);
    end
    chk("parked_gates", 32'(phase_gate), 32'd0);
    chk("parked_running", 32'(running), 32'd0);
    chk("parked_count", 32'(cycle_count), 32'd6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_sms_timing_ring
`default_nettype wire
